// File: rtl/reg_watch.sv
// reg_watch: taps the register-file write port, shadows up to NCH watched
// registers, logs time-stamped value changes into an event FIFO drained by a
// valid/ready consumer, and reports when the watched registers have settled.
module reg_watch #(
  parameter int NCH        = 4,
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 8,
  parameter int TSW        = 16,
  parameter int STABLE     = 16,
  parameter int ALL_WRITES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_waddr,
  input  logic [DW-1:0]     wb_wdata,
  input  logic [NCH*AW-1:0] watch_addr,
  output logic [NCH*DW-1:0] shadow,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_chan,
  output logic [DW-1:0]     ev_data,
  output logic [TSW-1:0]    ev_time,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic              settled
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);
  localparam logic [15:0]   ICNT_LAST  = 16'(STABLE - 1);
  localparam logic [TSW-1:0] TS_ONE    = {{(TSW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_SETTLED = 2'd2
  } state_t;

  // Shadow registers and match results
  logic [DW-1:0]  shadow_r [NCH];
  logic [NCH-1:0] hit_s;
  logic           any_hit_s;
  logic [2:0]     hit_chan_s;
  logic [DW-1:0]  old_val_s;
  logic           push_s;

  // Event FIFO: entry 0 is always the head, so head fields come straight
  // from registers and stay stable while the consumer stalls.
  logic [2:0]     chan_mem_r [DEPTH];
  logic [DW-1:0]  data_mem_r [DEPTH];
  logic [TSW-1:0] time_mem_r [DEPTH];
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_nxt_s;
  logic [CW-1:0]  wr_idx_s;
  logic           valid_r;
  logic           pop_s;
  logic           full_s;
  logic           accept_s;
  logic           drop_s;

  logic           overflow_r;
  logic [7:0]     drop_cnt_r;
  logic [TSW-1:0] ts_r;
  state_t         state_r;
  logic [15:0]    icnt_r;
  logic           settled_r;

  // Match every channel against the write port; descending scan leaves the lowest hitting channel selected
  always_comb begin
    hit_s      = {NCH{1'b0}};
    any_hit_s  = 1'b0;
    hit_chan_s = 3'd0;
    old_val_s  = {DW{1'b0}};
    for (int c = NCH - 1; c >= 0; c--) begin
      if (wb_we && (wb_waddr != {AW{1'b0}}) && (wb_waddr == watch_addr[c*AW +: AW])) begin
        hit_s[c]   = 1'b1;
        any_hit_s  = 1'b1;
        hit_chan_s = 3'(c);
        old_val_s  = shadow_r[c];
      end else begin
        hit_s[c] = 1'b0;
      end
    end
    push_s = any_hit_s && ((ALL_WRITES != 32'sd0) || (wb_wdata != old_val_s));
  end

  // FIFO control: pop/push qualification, next occupancy and write slot
  always_comb begin
    pop_s       = valid_r && ev_ready;
    full_s      = (count_r == CNT_DEPTH);
    accept_s    = push_s && (!full_s || pop_s);
    drop_s      = push_s && full_s && !pop_s;
    count_nxt_s = count_r;
    if (pop_s && accept_s) begin
      count_nxt_s = count_r;
    end else if (pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else if (accept_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (pop_s) begin
      wr_idx_s = count_r - CNT_ONE;
    end else begin
      wr_idx_s = count_r;
    end
  end

  // Shadow registers load write data on every hitting channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) shadow_r[c] <= {DW{1'b0}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hit_s[c]) shadow_r[c] <= wb_wdata;
      end
    end
  end

  // Free-running timestamp counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= {TSW{1'b0}};
    end else begin
      ts_r <= ts_r + TS_ONE;
    end
  end

  // Event FIFO storage: shift toward the head on pop, write the new event behind the last valid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        chan_mem_r[i] <= 3'd0;
        data_mem_r[i] <= {DW{1'b0}};
        time_mem_r[i] <= {TSW{1'b0}};
      end
      count_r <= CNT_ZERO;
      valid_r <= 1'b0;
    end else begin
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          chan_mem_r[i] <= chan_mem_r[i+1];
          data_mem_r[i] <= data_mem_r[i+1];
          time_mem_r[i] <= time_mem_r[i+1];
        end
        chan_mem_r[DEPTH-1] <= 3'd0;
        data_mem_r[DEPTH-1] <= {DW{1'b0}};
        time_mem_r[DEPTH-1] <= {TSW{1'b0}};
      end
      if (accept_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx_s == CW'(i)) begin
            chan_mem_r[i] <= hit_chan_s;
            data_mem_r[i] <= wb_wdata;
            time_mem_r[i] <= ts_r;
          end
        end
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  // Settle FSM: counts event-free cycles and flags settled after STABLE of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_UNARMED;
      icnt_r    <= 16'd0;
      settled_r <= 1'b0;
    end else begin
      case (state_r)
        ST_UNARMED: begin
          if (push_s) begin
            state_r <= ST_ACTIVE;
            icnt_r  <= 16'd0;
          end
          settled_r <= 1'b0;
        end
        ST_ACTIVE: begin
          if (push_s) begin
            icnt_r    <= 16'd0;
            settled_r <= 1'b0;
          end else if (icnt_r == ICNT_LAST) begin
            state_r   <= ST_SETTLED;
            settled_r <= 1'b1;
          end else begin
            icnt_r    <= icnt_r + 16'd1;
            settled_r <= 1'b0;
          end
        end
        ST_SETTLED: begin
          if (push_s) begin
            state_r   <= ST_ACTIVE;
            icnt_r    <= 16'd0;
            settled_r <= 1'b0;
          end else begin
            settled_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_UNARMED;
          icnt_r    <= 16'd0;
          settled_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_shadow
    assign shadow[g*DW +: DW] = shadow_r[g];
  end

  assign ev_valid = valid_r;
  assign ev_chan  = chan_mem_r[0];
  assign ev_data  = data_mem_r[0];
  assign ev_time  = time_mem_r[0];
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;
  assign settled  = settled_r;

endmodule

// File: tb/tb_reg_watch.sv
// Directed bench for reg_watch: two instances (value-change logging and
// all-writes logging) share the stimulus; expected values are hand-computed.
module tb_reg_watch;

  localparam int NCH = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 8;
  localparam int TSW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wb_we = 1'b0;
  logic [AW-1:0]     wb_waddr = '0;
  logic [DW-1:0]     wb_wdata = '0;
  logic [NCH*AW-1:0] watch_addr = '0;
  logic              ev_ready = 1'b0;

  logic [NCH*DW-1:0] a_shadow, b_shadow;
  logic              a_ev_valid, b_ev_valid;
  logic [2:0]        a_ev_chan, b_ev_chan;
  logic [DW-1:0]     a_ev_data, b_ev_data;
  logic [TSW-1:0]    a_ev_time, b_ev_time;
  logic              a_overflow, b_overflow;
  logic [7:0]        a_drop_cnt, b_drop_cnt;
  logic              a_settled, b_settled;

  int n_tests = 0;
  int n_fail = 0;
  int exp_q [8] = '{2, 3, 4, 5, 6, 7, 8, 11};

  reg_watch #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .TSW(TSW),
              .STABLE(4), .ALL_WRITES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .watch_addr(watch_addr), .shadow(a_shadow),
    .ev_valid(a_ev_valid), .ev_ready(ev_ready), .ev_chan(a_ev_chan),
    .ev_data(a_ev_data), .ev_time(a_ev_time), .overflow(a_overflow),
    .drop_cnt(a_drop_cnt), .settled(a_settled));

  reg_watch #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .TSW(TSW),
              .STABLE(4), .ALL_WRITES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .watch_addr(watch_addr), .shadow(b_shadow),
    .ev_valid(b_ev_valid), .ev_ready(ev_ready), .ev_chan(b_ev_chan),
    .ev_data(b_ev_data), .ev_time(b_ev_time), .overflow(b_overflow),
    .drop_cnt(b_drop_cnt), .settled(b_settled));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_watch(input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                           input logic [AW-1:0] c2, input logic [AW-1:0] c3);
    watch_addr = {c3, c2, c1, c0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_we = 1'b0;
    ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wb_we = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    ev_ready = 1'b1;
    @(posedge clk);
    #1;
    ev_ready = 1'b0;
  endtask

  initial begin
    // Reset state, checked while rst_n is low
    @(negedge clk);
    rst_n = 1'b0;
    set_watch(5'd6, 5'd0, 5'd7, 5'd8);
    #1;
    check_eq("rst_ev_valid", a_ev_valid, 1'b0);
    check_eq("rst_ev_chan", a_ev_chan, 3'd0);
    check_eq("rst_ev_data", a_ev_data, 32'd0);
    check_eq("rst_ev_time", a_ev_time, 16'd0);
    check_eq("rst_overflow", a_overflow | b_overflow, 1'b0);
    check_eq("rst_drop_cnt", a_drop_cnt | b_drop_cnt, 8'd0);
    check_eq("rst_settled", a_settled | b_settled, 1'b0);
    check_eq("rst_shadow", a_shadow | b_shadow, 128'd0);
    check_eq("rst_b_head", {b_ev_valid, b_ev_chan}, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First write: shadow and event visible after the sampling edge, stamp 1
    wr(5'd6, 32'h0000_3039);
    check_eq("t1_shadow0", a_shadow[31:0], 32'h3039);
    check_eq("t1_ev_valid", a_ev_valid, 1'b1);
    check_eq("t1_ev_chan", a_ev_chan, 3'd0);
    check_eq("t1_ev_data", a_ev_data, 32'h3039);
    check_eq("t1_ev_time", a_ev_time, 16'd1);

    // Same-value rewrite: logged only by the all-writes instance
    pop();
    check_eq("t2_empty_after_pop", a_ev_valid, 1'b0);
    wr(5'd6, 32'h0000_3039);
    check_eq("t2_a_no_event", a_ev_valid, 1'b0);
    check_eq("t2_b_event", b_ev_valid, 1'b1);
    check_eq("t2_b_data", b_ev_data, 32'h3039);
    check_eq("t2_b_time", b_ev_time, 16'd3);
    pop();

    // Two channels on one register: both shadows load, one event on ch0
    set_watch(5'd5, 5'd0, 5'd5, 5'd8);
    wr(5'd5, 32'd7);
    check_eq("t3_shadow0", a_shadow[31:0], 32'd7);
    check_eq("t3_shadow2", a_shadow[95:64], 32'd7);
    check_eq("t3_ev_chan", a_ev_chan, 3'd0);
    check_eq("t3_ev_data", a_ev_data, 32'd7);
    pop();
    check_eq("t3_single_event", a_ev_valid, 1'b0);
    wr(5'd0, 32'd9);
    check_eq("t3_x0_shadow1", a_shadow[63:32], 32'd0);
    check_eq("t3_x0_no_event", a_ev_valid, 1'b0);

    // Overflow: 10 distinct writes into a stalled 8-deep FIFO
    do_reset();
    set_watch(5'd6, 5'd0, 5'd7, 5'd8);
    for (int i = 1; i <= 10; i++) wr(5'd6, 32'(i));
    check_eq("t4_overflow", a_overflow, 1'b1);
    check_eq("t4_drop_cnt", a_drop_cnt, 8'd2);
    check_eq("t4_head", a_ev_data, 32'd1);
    // Pop and push together while full: nothing dropped
    @(negedge clk);
    ev_ready = 1'b1;
    wb_we = 1'b1;
    wb_waddr = 5'd6;
    wb_wdata = 32'd11;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    check_eq("t4_drop_unchanged", a_drop_cnt, 8'd2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t4_drain_valid", a_ev_valid, 1'b1);
      check_eq("t4_drain_data", a_ev_data, 32'(exp_q[k]));
      @(posedge clk);
    end
    #1;
    ev_ready = 1'b0;
    check_eq("t4_drained", a_ev_valid, 1'b0);

    // Settle: long idle already, then event / 4 idle edges / event
    check_eq("t5_settled_idle", a_settled, 1'b1);
    wr(5'd6, 32'd100);
    check_eq("t5_fall", a_settled, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_idle3", a_settled, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t5_idle4", a_settled, 1'b1);
    wr(5'd6, 32'd101);
    check_eq("t5_fall2", a_settled, 1'b0);
    check_eq("t5_queued_head", a_ev_data, 32'd100);

    // Asynchronous reset mid-queue, observed without any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_arst_valid", a_ev_valid, 1'b0);
    check_eq("t5_arst_overflow", a_overflow, 1'b0);
    check_eq("t5_arst_drop", a_drop_cnt, 8'd0);
    check_eq("t5_arst_shadow0", a_shadow[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timestamp wrap: write sampled after 65538 edges carries stamp 2
    repeat (65538) @(posedge clk);
    wr(5'd6, 32'd55);
    check_eq("t6_wrap_valid", a_ev_valid, 1'b1);
    check_eq("t6_wrap_data", a_ev_data, 32'd55);
    check_eq("t6_wrap_time", a_ev_time, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_watch.md
# reg_watch

Parametrised register-file watch unit for the RISC-V CPU. It taps the register-file write port and shadows up to NCH selected architectural registers. Each value change is logged as a time-stamped event into an internal FIFO, drained by a valid/ready consumer (HEX display driver or simulation monitor). It also detects when the watched registers have settled. It supersedes per-cycle printing of one hard-wired register and can be instantiated in both the FPGA top and the simulation top.

## Interface
- NCH, 4: number of watch channels (1-8)
- DW, 32: register data width
- AW, 5: register address width
- DEPTH, 8: event FIFO depth, power of two, ≥2
- TSW, 16: timestamp width
- STABLE, 16: idle cycles (1 to 2^16-1) before settled asserts
- ALL_WRITES, 0: 0 = log value changes only; 1 = log every watched write

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  register-file write enable (tap)
- wb_waddr  in  AW  register-file write address
- wb_wdata  in  DW  register-file write data
- watch_addr  in  NCH*AW  channel c address in bits [c*AW +: AW]; quasi-static
- shadow  out  NCH*DW  current shadow value per channel
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_chan  out  3  channel index of head event
- ev_data  out  DW  new value of head event
- ev_time  out  TSW  timestamp of head event
- overflow  out  1  sticky: an event was dropped
- drop_cnt  out  8  dropped events, saturating at 255
- settled  out  1  no watched change for STABLE cycles since the last change

## Operation
- Match: channel c hits when wb_we=1, wb_waddr==watch_addr[c], and wb_waddr!=0. Writes to x0 are ignored.
- Shadow update: every hitting channel loads wb_wdata at the sampling edge.
- Event generation: at most one per cycle.
  - Channel is the lowest hitting index.
  - Generated if ALL_WRITES=1, or if wb_wdata differs from that channel's shadow before the update.
- Timestamp: free-running TSW-bit counter, 0 after reset, +1 every cycle, wraps to 0. The event carries the counter value of the cycle in which the write was sampled.
- FIFO:
  - DEPTH entries; a pop occurs when ev_valid && ev_ready.
  - Full with push and no pop: event dropped, overflow set, drop_cnt increments (saturating).
  - Full with push and pop in the same cycle: both occur, nothing dropped.
  - Empty with push and ev_ready=1: no bypass; the event appears next cycle.
- Settle FSM, using idle counter icnt:
  - UNARMED → ACTIVE on the first generated event.
  - ACTIVE: icnt resets to 0 on each event, else +1. When icnt reaches STABLE-1 with no event that cycle, go to SETTLED.
  - SETTLED → ACTIVE on any event (icnt=0).
  - settled=1 only in SETTLED.
- Clearing: overflow and drop_cnt clear only on reset.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - all outputs (shadow, ev_valid, ev_chan, ev_data, ev_time, overflow, drop_cnt, settled) to 0;
  - FIFO empty, timestamp counter 0, FSM UNARMED, icnt 0.
- Release is synchronous to clk. Reset mid-operation discards all queued events.
- Write sampled at edge N:
  - shadow visible after edge N;
  - if the FIFO was empty, ev_valid=1 after edge N with head fields valid.
- Head fields are stable while ev_valid=1 and ev_ready=0. The next entry appears after the popping edge.
- settled rises at the edge that completes STABLE consecutive event-free cycles after the last event. It falls at the edge that samples a new event.

## Test plan
- Reset, then write x6=0x0000_3039 with watch_addr ch0=6 → shadow ch0=0x3039 one cycle later; ev_valid=1, ev_chan=0, ev_data=0x3039, ev_time equals the write cycle's stamp.
- Write x6=0x3039 again with ALL_WRITES=0 → no event, ev_valid stays 0 after the first pop. Repeat with ALL_WRITES=1 → event logged.
- ch0=ch2=5, write x5=7 → both shadows =7; a single event with ev_chan=0. Write x0=9 with ch1=0 → no shadow change, no event.
- ev_ready=0, 10 distinct writes, DEPTH=8 → 8 events queued in order; overflow=1, drop_cnt=2. With full FIFO, a simultaneous pop and push → drop_cnt unchanged.
- STABLE=4: event, then 4 idle cycles → settled=1 at the 4th idle edge; a new change → settled=0 next edge. Assert rst_n=0 mid-queue → ev_valid=0 and overflow=0 immediately (asynchronous).
- Run 2^TSW+3 cycles, then write → ev_time=2 (wrap checked).
